// File: rtl/laby4b_logic_unit.sv
// Registered 4-input Boolean function unit with a programmable 16-entry truth table
// and an on-chip sweep engine that captures the full table response for self-check.
module laby4b_logic_unit #(
  parameter logic [15:0] TRUTH_TABLE = 16'hF444
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a,
  input  logic        i_b,
  input  logic        i_c,
  input  logic        i_d,
  input  logic        i_tt_load,
  input  logic [15:0] i_tt_data,
  input  logic        i_sweep_start,
  output logic        o_y,
  output logic [3:0]  o_minterm,
  output logic [15:0] o_tt,
  output logic        o_sweep_busy,
  output logic        o_sweep_done,
  output logic [15:0] o_sweep_result
);

  typedef enum logic {IDLE, RUN} sweep_state_t;

  sweep_state_t state, state_next;
  logic [3:0]   index, index_next;
  logic [15:0]  tt;
  logic [15:0]  result, result_next;
  logic         done, done_next;
  logic [3:0]   minterm_in;

  assign minterm_in = {i_a, i_b, i_c, i_d};

  // Sweep sequencing: one table entry is captured per cycle while running.
  always_comb begin
    state_next  = state;
    index_next  = index;
    result_next = result;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (i_sweep_start) begin
          state_next  = RUN;
          index_next  = 4'd0;
          result_next = 16'h0000;
        end
      end
      RUN: begin
        result_next[index] = tt[index];
        index_next         = index + 4'd1;
        if (index == 4'd15) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      index  <= 4'd0;
      result <= 16'h0000;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      index  <= index_next;
      result <= result_next;
      done   <= done_next;
    end
  end

  // The loading edge still evaluates o_y with the old table; loads are locked out mid-sweep
  // so a running sweep always sees one consistent table.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tt        <= TRUTH_TABLE;
      o_y       <= 1'b0;
      o_minterm <= 4'd0;
    end else begin
      o_y       <= tt[minterm_in];
      o_minterm <= minterm_in;
      if (i_tt_load && (state == IDLE)) begin
        tt <= i_tt_data;
      end
    end
  end

  assign o_tt           = tt;
  assign o_sweep_busy   = (state == RUN);
  assign o_sweep_done   = done;
  assign o_sweep_result = result;

endmodule

// File: tb/tb_laby4b_logic_unit.sv
// Randomized and directed self-checking bench for laby4b_logic_unit against a
// behavioural model that tracks the table, the sweep countdown and the captured response.
module tb_laby4b_logic_unit;

  localparam logic [15:0] DEF_TT = 16'hF444;

  logic        clk;
  logic        rst;
  logic        a, b, c, d;
  logic        tt_load;
  logic [15:0] tt_data;
  logic        sweep_start;
  logic        y;
  logic [3:0]  minterm;
  logic [15:0] tt_out;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] sweep_result;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_y;
  logic [3:0]  m_minterm;
  logic [15:0] m_tt;
  int          m_left;
  int          m_swept;
  logic        m_done;
  logic [15:0] m_result;

  int busy_count;
  int done_count;

  laby4b_logic_unit #(.TRUTH_TABLE(DEF_TT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_a           (a),
    .i_b           (b),
    .i_c           (c),
    .i_d           (d),
    .i_tt_load     (tt_load),
    .i_tt_data     (tt_data),
    .i_sweep_start (sweep_start),
    .o_y           (y),
    .o_minterm     (minterm),
    .o_tt          (tt_out),
    .o_sweep_busy  (sweep_busy),
    .o_sweep_done  (sweep_done),
    .o_sweep_result(sweep_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then compares all outputs.
  task automatic applyStimulus(input logic [3:0] abcd, input logic ld, input logic [15:0] data,
                               input logic st, input logic rs);
    int mask;
    {a, b, c, d} = abcd;
    tt_load      = ld;
    tt_data      = data;
    sweep_start  = st;
    rst          = rs;
    @(posedge clk);
    if (rs) begin
      m_y = 1'b0; m_minterm = 4'd0; m_tt = DEF_TT;
      m_left = 0; m_swept = 0; m_done = 1'b0; m_result = 16'h0000;
    end else begin
      m_minterm = abcd;
      m_y       = m_tt[abcd];
      m_done    = 1'b0;
      if (m_left > 0) begin
        m_swept++;
        mask     = (1 << m_swept) - 1;
        m_result = m_tt & mask[15:0];
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else begin
        if (ld) m_tt = data;
        if (st) begin
          m_left   = 16;
          m_swept  = 0;
          m_result = 16'h0000;
        end
      end
    end
    #1;
    checkOutput("y",            {15'd0, y},          {15'd0, m_y});
    checkOutput("minterm",      {12'd0, minterm},    {12'd0, m_minterm});
    checkOutput("tt",           tt_out,              m_tt);
    checkOutput("sweep_busy",   {15'd0, sweep_busy}, {15'd0, (m_left > 0)});
    checkOutput("sweep_done",   {15'd0, sweep_done}, {15'd0, m_done});
    checkOutput("sweep_result", sweep_result,        m_result);
    busy_count += int'(sweep_busy);
    done_count += int'(sweep_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    m_y = 1'b0; m_minterm = 4'd0; m_tt = DEF_TT;
    m_left = 0; m_swept = 0; m_done = 1'b0; m_result = 16'h0000;
    busy_count = 0; done_count = 0;

    applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("reset_tt", tt_out, 16'hF444);

    // Default function over every minterm
    for (int k = 0; k < 16; k++) begin
      applyStimulus(4'(k), 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("default_y", {15'd0, y}, {15'd0, DEF_TT[k]});
    end

    // Plain sweep of the default table
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    busy_count = 0; done_count = 0;
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(18);
    checkOutput("sweep_busy_cycles", 16'(busy_count), 16'd16);
    checkOutput("sweep_done_pulses", 16'(done_count), 16'd1);
    checkOutput("sweep_default", sweep_result, 16'hF444);

    // AND4 table
    applyStimulus(4'd0, 1'b1, 16'h8000, 1'b0, 1'b0);
    applyStimulus(4'hF, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("and4_1111", {15'd0, y}, 16'd1);
    applyStimulus(4'hE, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("and4_1110", {15'd0, y}, 16'd0);
    checkOutput("and4_tt", tt_out, 16'h8000);

    // Load and restart are ignored mid-sweep
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(3);
    applyStimulus(4'd5, 1'b1, 16'h0001, 1'b0, 1'b0);
    idle(2);
    applyStimulus(4'd9, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(14);
    checkOutput("ignored_result", sweep_result, 16'hF444);
    checkOutput("ignored_tt", tt_out, 16'hF444);

    // Reset mid-sweep aborts
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(6);
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("abort_busy", {15'd0, sweep_busy}, 16'd0);
    checkOutput("abort_done", {15'd0, sweep_done}, 16'd0);
    checkOutput("abort_result", sweep_result, 16'h0000);
    checkOutput("abort_tt", tt_out, 16'hF444);

    // Load and start on the same edge: sweep sees the new table
    applyStimulus(4'd0, 1'b1, 16'h6996, 1'b1, 1'b0);
    idle(17);
    checkOutput("xor4_result", sweep_result, 16'h6996);

    // Start accepted on the edge where done is high
    applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(15);
    applyStimulus(4'd3, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("b2b_done", {15'd0, sweep_done}, 16'd1);
    applyStimulus(4'd0, 1'b1, 16'hA5A5, 1'b1, 1'b0);
    checkOutput("b2b_busy", {15'd0, sweep_busy}, 16'd1);
    idle(17);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0),
                    16'($urandom),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
